// File: rtl/video_sig_if.sv
// video_sig_if: pixel stream in, capture control and signature results out
interface video_sig_if #(
  parameter int PIXW  = 24,
  parameter int PIXCW = 10,
  parameter int LINEW = 9
);
  logic             CE;
  logic             DE;
  logic             VS;
  logic [PIXW-1:0]  RGB;
  logic             ARM;
  logic             BUSY;
  logic             DONE;
  logic [31:0]      SIG;
  logic [PIXCW-1:0] PIXELS;
  logic [LINEW-1:0] LINES;
  logic             ERR;
  modport master (output CE, DE, VS, RGB, ARM, input BUSY, DONE, SIG, PIXELS, LINES, ERR);
  modport slave  (input CE, DE, VS, RGB, ARM, output BUSY, DONE, SIG, PIXELS, LINES, ERR);
endinterface

// File: rtl/video_sig.sv
// video_sig: CRC-32 signature over visible pixels of FRAMES frames, plus line length/count checks
module video_sig #(
  parameter int PIXW   = 24,
  parameter int PIXCW  = 10,
  parameter int LINEW  = 9,
  parameter int FRAMES = 1
) (
  input logic        CLK,
  input logic        nRES,
  video_sig_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;
  state_t           r_state, w_next;
  logic             r_de, r_vs, r_vs_d, r_open, r_first, r_err;
  logic [PIXW-1:0]  r_rgb;
  logic [31:0]      r_crc, r_sig, w_crc_n;
  logic [PIXCW-1:0] r_pcnt, r_pixels, w_pcnt_n;
  logic [LINEW-1:0] r_lcnt, r_lines, w_lcnt_n;
  logic [7:0]       r_fcnt, w_fcnt_n;
  logic             w_cap, w_pix, w_vs_rise, w_fend, w_lend, w_last, w_err_n;

  // reflected CRC-32, bit 0 of the pixel first: bytes LSB-first, low byte first
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PIXW-1:0] d);
    logic [31:0] acc;
    acc = c;
    for (int i = 0; i < PIXW; i++) acc = (acc >> 1) ^ ((acc[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return acc;
  endfunction

  // processing runs one CE behind the inputs; a line left open at a VS rise is closed there
  always_comb begin
    w_cap     = r_state == S_CAP && bus.CE;
    w_pix     = w_cap && r_de;
    w_vs_rise = bus.CE && r_vs && !r_vs_d;
    w_fend    = w_cap && w_vs_rise;
    w_pcnt_n  = r_pcnt + PIXCW'(w_pix && !(&r_pcnt));
    w_lend    = w_cap && (r_open || w_pix) && (!r_de || w_vs_rise);
    w_lcnt_n  = r_lcnt + LINEW'(w_lend && !(&r_lcnt));
    w_fcnt_n  = r_fcnt + 8'd1;
    w_last    = w_fend && w_fcnt_n == 8'(FRAMES);
    w_crc_n   = w_pix ? crc_step(r_crc, r_rgb) : r_crc;
    w_err_n   = r_err || (w_pix && &r_pcnt) || (w_lend && &r_lcnt) ||
                (w_lend && !r_first && w_pcnt_n != r_pixels);
  end

  always_comb begin
    w_next = bus.ARM ? S_WAIT : (r_state == S_WAIT && w_vs_rise) ? S_CAP : w_last ? S_DONE : r_state;
  end

  always_ff @(posedge CLK or negedge nRES)
    if (!nRES) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge CLK or negedge nRES)
    if (!nRES) begin
      {r_de, r_vs, r_vs_d, r_open, r_first, r_err} <= '0;
      r_rgb    <= '0;
      r_crc    <= '1;
      r_sig    <= '0;
      r_pcnt   <= '0;
      r_pixels <= '0;
      r_lcnt   <= '0;
      r_lines  <= '0;
      r_fcnt   <= '0;
    end else begin
      if (bus.CE) begin
        r_de   <= bus.DE;
        r_vs   <= bus.VS;
        r_vs_d <= r_vs;
        r_rgb  <= bus.RGB;
      end
      if (bus.ARM) begin
        r_crc    <= '1;
        r_pcnt   <= '0;
        r_lcnt   <= '0;
        r_fcnt   <= '0;
        r_pixels <= '0;
        r_lines  <= '0;
        r_err    <= 1'b0;
        r_open   <= 1'b0;
        r_first  <= 1'b1;
      end else if (w_cap) begin
        r_crc  <= w_crc_n;
        r_err  <= w_err_n;
        r_open <= (r_open || w_pix) && !w_lend;
        r_pcnt <= w_lend ? '0 : w_pcnt_n;
        r_lcnt <= w_fend ? '0 : w_lcnt_n;
        if (w_lend && r_first) begin
          r_pixels <= w_pcnt_n;
          r_first  <= 1'b0;
        end
        if (w_fend) begin
          r_lines <= w_lcnt_n;
          r_fcnt  <= w_fcnt_n;
        end
        if (w_last) r_sig <= ~w_crc_n;
      end
    end

  assign bus.BUSY   = r_state == S_WAIT || r_state == S_CAP;
  assign bus.DONE   = r_state == S_DONE;
  assign bus.SIG    = r_sig;
  assign bus.PIXELS = r_pixels;
  assign bus.LINES  = r_lines;
  assign bus.ERR    = r_err;
endmodule

// File: tb/tb_video_sig.sv
// tb_video_sig: directed vectors for video_sig, one FRAMES=1 and one FRAMES=2 instance on the same stream
module tb_video_sig;
  logic clk = 1'b0;
  logic nres = 1'b0;
  always #5 clk = ~clk;

  video_sig_if #(.PIXW(24), .PIXCW(10), .LINEW(9)) b1 ();
  video_sig_if #(.PIXW(24), .PIXCW(10), .LINEW(9)) b2 ();
  video_sig #(.PIXW(24), .PIXCW(10), .LINEW(9), .FRAMES(1)) dut  (.CLK(clk), .nRES(nres), .bus(b1));
  video_sig #(.PIXW(24), .PIXCW(10), .LINEW(9), .FRAMES(2)) dut2 (.CLK(clk), .nRES(nres), .bus(b2));
  assign b2.CE  = b1.CE;
  assign b2.DE  = b1.DE;
  assign b2.VS  = b1.VS;
  assign b2.RGB = b1.RGB;
  assign b2.ARM = b1.ARM;

  typedef struct {
    int         npix;
    int         nl;
    int         sl;
    int         slen;
    int         gap;
    logic [9:0] pixels;
    logic [8:0] lines;
    logic       err;
  } vec_t;
  vec_t        tv [7];
  int          n_tests = 0;
  int          n_fail = 0;
  int          ce_gap = 0;
  logic [31:0] m_crc = 32'hFFFFFFFF;
  logic [31:0] c1;

  function automatic logic [31:0] crc_px(input logic [31:0] c, input logic [23:0] px);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 3; k++) begin
      r ^= {24'd0, px[8*k +: 8]};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [23:0] pix(input int seed, input int l, input int x);
    return {8'(seed + l), 8'(l * 7 + x), 8'(x)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic ce_cyc(input logic de, input logic vs, input logic [23:0] rgb);
    b1.CE = 1'b1; b1.DE = de; b1.VS = vs; b1.RGB = rgb;
    tick();
    for (int i = 0; i < ce_gap; i++) begin
      b1.CE = 1'b0; b1.DE = ~de; b1.VS = ~vs; b1.RGB = 24'($urandom);
      tick();
    end
  endtask

  task automatic vs_pulse();
    ce_cyc(1'b0, 1'b1, 24'd0);
    ce_cyc(1'b0, 1'b1, 24'd0);
    ce_cyc(1'b0, 1'b0, 24'd0);
    ce_cyc(1'b0, 1'b0, 24'd0);
  endtask

  task automatic arm();
    b1.CE = 1'b0; b1.ARM = 1'b1;
    tick();
    b1.ARM = 1'b0;
    m_crc = 32'hFFFFFFFF;
  endtask

  task automatic send_lines(input int npix, input int nl, input int sl, input int slen, input int seed);
    logic [23:0] px;
    for (int l = 0; l < nl; l++) begin
      for (int x = 0; x < ((l == sl) ? slen : npix); x++) begin
        px = pix(seed, l, x);
        m_crc = crc_px(m_crc, px);
        ce_cyc(1'b1, 1'b0, px);
      end
      ce_cyc(1'b0, 1'b0, 24'd0);
    end
  endtask

  initial begin
    tv[0] = '{4,    3, -1, 0,    1, 10'd4,    9'd3, 1'b0};
    tv[1] = '{1,    1, -1, 0,    2, 10'd1,    9'd1, 1'b0};
    tv[2] = '{256,  8,  5, 255,  0, 10'd256,  9'd8, 1'b1};
    tv[3] = '{5,    2,  0, 3,    1, 10'd3,    9'd2, 1'b1};
    tv[4] = '{7,    3,  2, 9,    0, 10'd7,    9'd3, 1'b1};
    tv[5] = '{1023, 1, -1, 0,    0, 10'd1023, 9'd1, 1'b0};
    tv[6] = '{1024, 1, -1, 0,    0, 10'd1023, 9'd1, 1'b1};
    b1.CE = 1'b0; b1.DE = 1'b0; b1.VS = 1'b0; b1.RGB = '0; b1.ARM = 1'b0;
    tick(); tick();
    nres = 1'b1;
    tick();
    chk("rst busy", 32'(b1.BUSY), 0);
    chk("rst done", 32'(b1.DONE), 0);
    // known CRC: "123456789"
    arm();
    chk("arm busy", 32'(b1.BUSY), 1);
    vs_pulse();
    ce_cyc(1'b1, 1'b0, 24'h333231);
    ce_cyc(1'b1, 1'b0, 24'h363534);
    ce_cyc(1'b1, 1'b0, 24'h393837);
    ce_cyc(1'b0, 1'b0, 24'd0);
    vs_pulse();
    chk("crc9 done", 32'(b1.DONE), 1);
    chk("crc9 busy", 32'(b1.BUSY), 0);
    chk("crc9 sig", b1.SIG, 32'hCBF43926);
    chk("crc9 pixels", 32'(b1.PIXELS), 3);
    chk("crc9 lines", 32'(b1.LINES), 1);
    chk("crc9 err", 32'(b1.ERR), 0);
    // asynchronous reset mid-capture
    arm();
    vs_pulse();
    send_lines(4, 2, -1, 0, 2);
    #2 nres = 1'b0;
    #1;
    chk("mid rst busy", 32'(b1.BUSY), 0);
    chk("mid rst done", 32'(b1.DONE), 0);
    chk("mid rst sig", b1.SIG, 0);
    chk("mid rst pixels", 32'(b1.PIXELS), 0);
    chk("mid rst lines", 32'(b1.LINES), 0);
    chk("mid rst err", 32'(b1.ERR), 0);
    tick();
    nres = 1'b1;
    tick();
    vs_pulse();
    send_lines(4, 1, -1, 0, 2);
    vs_pulse();
    chk("post rst done", 32'(b1.DONE), 0);
    chk("post rst busy", 32'(b1.BUSY), 0);
    chk("post rst pixels", 32'(b1.PIXELS), 0);
    // table of frame shapes
    for (int i = 0; i < 7; i++) begin
      ce_gap = tv[i].gap;
      arm();
      vs_pulse();
      send_lines(tv[i].npix, tv[i].nl, tv[i].sl, tv[i].slen, i + 1);
      vs_pulse();
      chk($sformatf("v%0d done", i), 32'(b1.DONE), 1);
      chk($sformatf("v%0d pixels", i), 32'(b1.PIXELS), 32'(tv[i].pixels));
      chk($sformatf("v%0d lines", i), 32'(b1.LINES), 32'(tv[i].lines));
      chk($sformatf("v%0d err", i), 32'(b1.ERR), 32'(tv[i].err));
      chk($sformatf("v%0d sig", i), b1.SIG, ~m_crc);
    end
    ce_gap = 0;
    // full 256x192 frame, DONE exactly on the VS-rise CE cycle
    arm();
    vs_pulse();
    send_lines(256, 192, -1, 0, 3);
    ce_cyc(1'b0, 1'b1, 24'd0);
    chk("full early done", 32'(b1.DONE), 0);
    ce_cyc(1'b0, 1'b1, 24'd0);
    chk("full done", 32'(b1.DONE), 1);
    chk("full busy", 32'(b1.BUSY), 0);
    ce_cyc(1'b0, 1'b0, 24'd0);
    chk("full pixels", 32'(b1.PIXELS), 256);
    chk("full lines", 32'(b1.LINES), 192);
    chk("full err", 32'(b1.ERR), 0);
    chk("full sig", b1.SIG, ~m_crc);
    // two frames folded into one signature
    arm();
    vs_pulse();
    send_lines(6, 4, -1, 0, 9);
    c1 = m_crc;
    vs_pulse();
    chk("mf f1 done", 32'(b1.DONE), 1);
    chk("mf f1 sig", b1.SIG, ~c1);
    chk("mf2 mid done", 32'(b2.DONE), 0);
    chk("mf2 mid busy", 32'(b2.BUSY), 1);
    send_lines(6, 4, -1, 0, 9);
    vs_pulse();
    chk("mf2 done", 32'(b2.DONE), 1);
    chk("mf2 sig", b2.SIG, ~m_crc);
    chk("mf2 pixels", 32'(b2.PIXELS), 6);
    chk("mf2 lines", 32'(b2.LINES), 4);
    chk("mf2 err", 32'(b2.ERR), 0);
    chk("mf f1 sig held", b1.SIG, ~c1);
    // ARM mid-frame restarts at the next VS rise
    arm();
    vs_pulse();
    send_lines(16, 2, -1, 0, 1);
    b1.ARM = 1'b1;
    ce_cyc(1'b1, 1'b0, 24'h123456);
    b1.ARM = 1'b0;
    chk("rearm busy", 32'(b1.BUSY), 1);
    chk("rearm pixels", 32'(b1.PIXELS), 0);
    chk("rearm lines", 32'(b1.LINES), 0);
    send_lines(16, 1, -1, 0, 5);
    vs_pulse();
    m_crc = 32'hFFFFFFFF;
    send_lines(5, 2, -1, 0, 4);
    vs_pulse();
    chk("rearm done", 32'(b1.DONE), 1);
    chk("rearm new pixels", 32'(b1.PIXELS), 5);
    chk("rearm new lines", 32'(b1.LINES), 2);
    chk("rearm sig", b1.SIG, ~m_crc);
    // ARM on the closing VS rise wins over DONE
    arm();
    vs_pulse();
    send_lines(3, 2, -1, 0, 7);
    ce_cyc(1'b0, 1'b1, 24'd0);
    b1.ARM = 1'b1;
    ce_cyc(1'b0, 1'b1, 24'd0);
    b1.ARM = 1'b0;
    chk("coinc done", 32'(b1.DONE), 0);
    chk("coinc busy", 32'(b1.BUSY), 1);
    chk("coinc lines", 32'(b1.LINES), 0);
    ce_cyc(1'b0, 1'b0, 24'd0);
    ce_cyc(1'b0, 1'b0, 24'd0);
    chk("coinc still waiting", 32'(b1.DONE), 0);
    vs_pulse();
    m_crc = 32'hFFFFFFFF;
    send_lines(2, 1, -1, 0, 6);
    vs_pulse();
    chk("coinc after done", 32'(b1.DONE), 1);
    chk("coinc after pixels", 32'(b1.PIXELS), 2);
    chk("coinc after lines", 32'(b1.LINES), 1);
    chk("coinc after sig", b1.SIG, ~m_crc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
